// File: rtl/ws_pe_driver.sv
// ws_pe_driver: sequences one weight-stationary PE through a dot-product job.
// The PE accumulator is never cleared, so the job result is the difference
// between the accumulator at job end and a snapshot taken at job start.
module ws_pe_driver #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [DATA_WIDTH-1:0]   job_weight,
    input  logic [LEN_W-1:0]        job_len,
    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic [DATA_WIDTH-1:0]   act_data,
    output logic                    pe_load_w,
    output logic [DATA_WIDTH-1:0]   pe_w,
    output logic                    pe_valid_in,
    output logic [DATA_WIDTH-1:0]   pe_a,
    input  logic [2*DATA_WIDTH-1:0] pe_accum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    busy
);

    localparam int unsigned ACC_W = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        CAPTURE,
        RESULT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   count;
    logic [ACC_W-1:0]   base;

    // State register; job_ready is a flop so it stays low while rst_n is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            job_ready <= 1'b0;
        end else begin
            state     <= state_next;
            job_ready <= (state_next == IDLE);
        end
    end

    // Next-state and state-decoded handshake/strobe outputs
    always_comb begin
        state_next  = state;
        act_ready   = 1'b0;
        pe_load_w   = 1'b0;
        pe_valid_in = 1'b0;
        pe_a        = act_data;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (job_valid && job_ready) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                pe_load_w  = 1'b1;
                state_next = (count == '0) ? CAPTURE : STREAM;
            end
            STREAM: begin
                act_ready   = 1'b1;
                pe_valid_in = act_valid;
                if (act_valid && (count == LEN_W'(1))) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job datapath: weight/count capture, base snapshot, modular difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_w     <= '0;
            count    <= '0;
            base     <= '0;
            res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        pe_w  <= job_weight;
                        count <= job_len;
                    end
                end
                LOAD: begin
                    base <= pe_accum;
                end
                STREAM: begin
                    if (act_valid) begin
                        count <= count - LEN_W'(1);
                    end
                end
                CAPTURE: begin
                    res_data <= pe_accum - base;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
